// File: rtl/cdcm8_tx_pkg.sv
// Shared constants for the CDCM-8 transmit modulator: word patterns, FSM encodings,
// counter widths and PRBS7 parameters. The receive side imports the same patterns.
package cdcm8_tx_pkg;

  // Rising edge always at bit 7; only the falling edge position carries information.
  localparam logic [7:0] kPatIdle = 8'b1111_0000;
  localparam logic [7:0] kPatZero = 8'b1110_0000;
  localparam logic [7:0] kPatOne  = 8'b1111_1000;

  localparam int kStateW = 2;
  typedef logic [kStateW-1:0] txState_t;

  localparam txState_t kStRst   = 2'd0;
  localparam txState_t kStTrain = 2'd1;
  localparam txState_t kStSync  = 2'd2;
  localparam txState_t kStRun   = 2'd3;

  localparam int kTrainCntW = 17;
  localparam int kSyncCntW  = 10;

  // x^7 + x^6 + 1, taps on register bits 6 and 5.
  localparam logic [6:0] kPrbsSeed = 7'h7F;
  localparam logic [6:0] kPrbsTaps = 7'b110_0000;

  function automatic logic [7:0] dataPattern(input logic bitVal);
    return bitVal ? kPatOne : kPatZero;
  endfunction

endpackage

// File: rtl/cdcm8_tx_prbs7.sv
// PRBS7 source for link testing; compiled only when CDCM_TX_PRBS_EN is defined.
`ifdef CDCM_TX_PRBS_EN
module cdcm8_tx_prbs7
  import cdcm8_tx_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic reseed_i,
  output logic bit_o
);

  logic [6:0] lfsr_q;
  logic [6:0] lfsr_d;
  logic       feedback;

  assign feedback = ^(lfsr_q & kPrbsTaps);
  assign bit_o    = lfsr_q[6];

  always_comb begin
    lfsr_d = lfsr_q;
    if (reseed_i) begin
      lfsr_d = kPrbsSeed;
    end else if (en_i) begin
      lfsr_d = {lfsr_q[5:0], feedback};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= kPrbsSeed;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule
`endif

// File: rtl/cdcm8_tx_modulator.sv
// CDCM-8 transmit modulator: TRAIN -> SYNC -> RUN sequencing and duty-cycle word encoding.
// Optional PRBS7 payload source is enabled by defining CDCM_TX_PRBS_EN.
module cdcm8_tx_modulator
  import cdcm8_tx_pkg::*;
#(
  parameter int unsigned kTrainCycles = 65536,
  parameter int unsigned kSyncCycles  = 256,
  parameter string       kTxPolarity  = "FALSE"
) (
  input  logic       clkDivIn,
  input  logic       pwrOnRst,
  input  logic       initIn,
  input  logic       dataIn,
  input  logic       validIn,
  output logic       readyOut,
  input  logic       prbsModeIn,
  output logic       linkUpOut,
  output logic       trainingOut,
  output logic [7:0] dOutToDevice
);

  localparam logic                  kInvert    = (kTxPolarity == "TRUE");
  localparam logic [7:0]            kPolMask   = {8{kInvert}};
  localparam logic [kTrainCntW-1:0] kTrainLast = kTrainCntW'(kTrainCycles - 1);
  localparam logic [kSyncCntW-1:0]  kSyncLast  = kSyncCntW'(kSyncCycles - 1);

  txState_t              state_q,    state_d;
  logic [kTrainCntW-1:0] trainCnt_q, trainCnt_d;
  logic [kSyncCntW-1:0]  syncCnt_q,  syncCnt_d;
  logic [7:0]            dOut_q,     dOut_d;
  logic                  linkUp_q,   linkUp_d;
  logic                  training_q, training_d;

  logic       effValid;
  logic       effData;
  logic       xfer;
  logic [7:0] patWord;

  assign readyOut = (state_q == kStRun) && !initIn;
  assign xfer     = effValid && readyOut;

`ifdef CDCM_TX_PRBS_EN
  logic prbsBit;
  logic prbsActive;
  logic prbsReseed;

  assign prbsActive = prbsModeIn && (state_q == kStRun);
  assign effValid   = validIn || prbsActive;
  assign effData    = prbsActive ? prbsBit : dataIn;
  assign prbsReseed = (state_q != kStRun) && (state_d == kStRun);

  cdcm8_tx_prbs7 uPrbs (
    .clk_i    (clkDivIn),
    .rst_i    (pwrOnRst),
    .en_i     (xfer && prbsActive),
    .reseed_i (prbsReseed),
    .bit_o    (prbsBit)
  );
`else
  logic unusedPrbsMode;

  assign unusedPrbsMode = prbsModeIn;
  assign effValid       = validIn;
  assign effData        = dataIn;
`endif

  // Counters only advance below their terminal count, so they saturate rather than wrap.
  always_comb begin
    state_d    = state_q;
    trainCnt_d = trainCnt_q;
    syncCnt_d  = syncCnt_q;
    case (state_q)
      kStRst: begin
        state_d    = kStTrain;
        trainCnt_d = '0;
      end
      kStTrain: begin
        if (trainCnt_q == kTrainLast) begin
          state_d   = kStSync;
          syncCnt_d = '0;
        end else begin
          trainCnt_d = trainCnt_q + 1'b1;
        end
      end
      kStSync: begin
        if (syncCnt_q == kSyncLast) begin
          state_d = kStRun;
        end else begin
          syncCnt_d = syncCnt_q + 1'b1;
        end
      end
      kStRun: begin
        state_d = kStRun;
      end
      default: begin
        state_d = kStRst;
      end
    endcase
    if (initIn && (state_q != kStRst)) begin
      state_d    = kStTrain;
      trainCnt_d = '0;
      syncCnt_d  = '0;
    end
  end

  // The word is chosen from the state being entered so it lines up with the registered flags.
  always_comb begin
    patWord = 8'h00;
    case (state_d)
      kStTrain: patWord = kPatIdle;
      kStSync:  patWord = syncCnt_d[0] ? kPatZero : kPatOne;
      kStRun:   patWord = xfer ? dataPattern(effData) : kPatIdle;
      default:  patWord = 8'h00;
    endcase
    dOut_d     = patWord ^ kPolMask;
    linkUp_d   = (state_d == kStRun);
    training_d = (state_d == kStTrain) || (state_d == kStSync);
  end

  always_ff @(posedge clkDivIn or posedge pwrOnRst) begin
    if (pwrOnRst) begin
      state_q    <= kStRst;
      trainCnt_q <= '0;
      syncCnt_q  <= '0;
      dOut_q     <= kPolMask;
      linkUp_q   <= 1'b0;
      training_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      trainCnt_q <= trainCnt_d;
      syncCnt_q  <= syncCnt_d;
      dOut_q     <= dOut_d;
      linkUp_q   <= linkUp_d;
      training_q <= training_d;
    end
  end

  assign dOutToDevice = dOut_q;
  assign linkUpOut    = linkUp_q;
  assign trainingOut  = training_q;

endmodule
